cv32e40p_apu_bridge: RTL and testbench

Credit-based bridge between the EX stage APU port (`apu_req`/`apu_gnt`/`apu_rvalid`) and an external vector accelerator that uses a valid/ready request channel and a valid/ready response channel. It sits directly downstream of the EX stage.

- **Request path:** registers the granted operation into a one-entry request slot.
- **Response path:** buffers accelerator results in an in-order FIFO and returns them to EX as single-cycle `apu_rvalid` pulses.
- **Flow control:** a credit counter bounds outstanding operations so the response FIFO can never overflow.

---
 rtl/cv32e40p_apu_bridge_if.sv | 81 ++++++++
 rtl/cv32e40p_apu_bridge.sv | 173 +++++++++++++++++
 tb/tb_cv32e40p_apu_bridge.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40p_apu_bridge_if.sv
// -----------------------------------------------------------------------------
// cv32e40p_apu_bridge_if
//
// Purpose: bundles every handshake and data signal between the EX stage APU
// port, the external accelerator and the cv32e40p_apu_bridge. The signal names
// keep the bridge's point of view: an _i suffix is a bridge input and an _o
// suffix is a bridge output.
//
// Modports:
//   slave  - the bridge itself. It drives grant, result, accelerator request
//            and response ready, and busy.
//   master - the environment, meaning EX plus the accelerator. It drives the
//            request, operands, hold, accelerator ready and response.
//
// Signal summary:
//   apu_req_i / apu_gnt_o           EX offload request and combinational grant
//   apu_operands_i / apu_op_i       operation captured on grant
//   apu_rvalid_o / apu_result_o     single-cycle result pulse to EX
//   rsp_hold_i                      EX cannot take a result this cycle
//   acc_req_valid_o / _ready_i      accelerator request channel
//   acc_req_op_o / _operands_o      registered request payload
//   acc_rsp_valid_i / _data_i       accelerator response channel
//   acc_rsp_ready_o                 response FIFO not full
//   busy_o                          at least one operation outstanding
// -----------------------------------------------------------------------------
interface cv32e40p_apu_bridge_if #(
   parameter int APU_NARGS_CPU = 3,
   parameter int APU_WOP_CPU   = 6
);
   logic                           apu_req_i;
   logic                           apu_gnt_o;
   logic [APU_NARGS_CPU-1:0][31:0] apu_operands_i;
   logic [APU_WOP_CPU-1:0]         apu_op_i;
   logic                           apu_rvalid_o;
   logic [31:0]                    apu_result_o;
   logic                           rsp_hold_i;
   logic                           acc_req_valid_o;
   logic                           acc_req_ready_i;
   logic [APU_WOP_CPU-1:0]         acc_req_op_o;
   logic [APU_NARGS_CPU-1:0][31:0] acc_req_operands_o;
   logic                           acc_rsp_valid_i;
   logic [31:0]                    acc_rsp_data_i;
   logic                           acc_rsp_ready_o;
   logic                           busy_o;

   modport slave (
      input  apu_req_i,
      input  apu_operands_i,
      input  apu_op_i,
      input  rsp_hold_i,
      input  acc_req_ready_i,
      input  acc_rsp_valid_i,
      input  acc_rsp_data_i,
      output apu_gnt_o,
      output apu_rvalid_o,
      output apu_result_o,
      output acc_req_valid_o,
      output acc_req_op_o,
      output acc_req_operands_o,
      output acc_rsp_ready_o,
      output busy_o
   );

   modport master (
      output apu_req_i,
      output apu_operands_i,
      output apu_op_i,
      output rsp_hold_i,
      output acc_req_ready_i,
      output acc_rsp_valid_i,
      output acc_rsp_data_i,
      input  apu_gnt_o,
      input  apu_rvalid_o,
      input  apu_result_o,
      input  acc_req_valid_o,
      input  acc_req_op_o,
      input  acc_req_operands_o,
      input  acc_rsp_ready_o,
      input  busy_o
   );
endinterface

// File: rtl/cv32e40p_apu_bridge.sv
// -----------------------------------------------------------------------------
// cv32e40p_apu_bridge
//
// Purpose: credit-based bridge between the EX stage APU port and an external
// accelerator that uses valid/ready request and response channels.
//   - Each granted operation is registered into a one-entry request slot that
//     feeds the accelerator.
//   - Accelerator results are buffered in an in-order circular FIFO and handed
//     back to EX as single-cycle apu_rvalid pulses.
//   - A credit counter limits the number of outstanding operations to DEPTH.
//     An operation counts from its grant until its result is popped, so every
//     result always has a FIFO entry waiting for it.
//
// Ports:
//   clk  - clock; all state changes on the rising edge
//   rst  - asynchronous, active-high reset
//   bus  - cv32e40p_apu_bridge_if.slave, which carries every EX and
//          accelerator signal
//
// Parameters:
//   APU_NARGS_CPU - number of 32-bit operands per request
//   APU_WOP_CPU   - opcode width
//   DEPTH         - response FIFO depth and credit limit (must be >= 1)
// -----------------------------------------------------------------------------
module cv32e40p_apu_bridge #(
   parameter int APU_NARGS_CPU = 3,
   parameter int APU_WOP_CPU   = 6,
   parameter int DEPTH         = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   cv32e40p_apu_bridge_if.slave        bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [CNT_W-1:0]               r_credits;
   logic                           r_req_valid;
   logic [APU_WOP_CPU-1:0]         r_req_op;
   logic [APU_NARGS_CPU-1:0][31:0] r_req_operands;

   logic [31:0]                    r_fifo_mem [DEPTH];
   logic [PTR_W-1:0]               r_wr_ptr;
   logic [PTR_W-1:0]               r_rd_ptr;
   logic [CNT_W-1:0]               r_count;

   // ---------------------------------------------------------------------
   // Combinational control
   // ---------------------------------------------------------------------
   logic w_slot_free;
   logic w_gnt;
   logic w_empty;
   logic w_full;
   logic w_push;
   logic w_pop;

   // The slot counts as free when it is empty or when it drains this cycle.
   // This lets a new operation refill the slot back to back.
   assign w_slot_free = ~r_req_valid | bus.acc_req_ready_i;
   assign w_gnt       = bus.apu_req_i & (r_credits < CNT_MAX) & w_slot_free;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_MAX);

   // The credit rule already prevents overflow. The full gate stays in as a
   // safety net in case the accelerator sends a response it was never asked for.
   assign w_push = bus.acc_rsp_valid_i & ~w_full;
   assign w_pop  = ~w_empty & ~bus.rsp_hold_i;

   // Pointers wrap explicitly, so DEPTH does not need to be a power of two.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_LAST) begin
         return '0;
      end
      return ptr + PTR_ONE;
   endfunction

   // ---------------------------------------------------------------------
   // Credit counter: +1 per grant, -1 per result popped to EX.
   // If a grant and a pop happen in the same cycle, the count is unchanged.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_credits <= '0;
      end else if (w_gnt & ~w_pop) begin
         r_credits <= r_credits + CNT_ONE;
      end else if (~w_gnt & w_pop) begin
         r_credits <= r_credits - CNT_ONE;
      end
   end

   // ---------------------------------------------------------------------
   // Request slot. A grant wins over a drain in the same cycle, so the slot
   // stays valid and holds the new operation. With no grant and no drain,
   // the payload holds steady for the accelerator.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req_valid <= 1'b0;
         r_req_op    <= '0;
      end else if (w_gnt) begin
         r_req_valid <= 1'b1;
         r_req_op    <= bus.apu_op_i;
      end else if (r_req_valid & bus.acc_req_ready_i) begin
         r_req_valid <= 1'b0;
      end
   end

   for (genvar gi = 0; gi < APU_NARGS_CPU; gi++) begin : g_operand
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_req_operands[gi] <= '0;
         end else if (w_gnt) begin
            r_req_operands[gi] <= bus.apu_operands_i[gi];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Response FIFO
   // ---------------------------------------------------------------------
   // The storage has no reset. Reading is gated by the count, so stale
   // entries are never visible to EX.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_mem[r_wr_ptr] <= bus.acc_rsp_data_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= next_ptr(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         if (w_push & ~w_pop) begin
            r_count <= r_count + CNT_ONE;
         end else if (~w_push & w_pop) begin
            r_count <= r_count - CNT_ONE;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign bus.apu_gnt_o          = w_gnt;
   assign bus.apu_rvalid_o       = w_pop;
   // The result is driven as zero whenever no pulse is present, so EX sees a
   // clean bus.
   assign bus.apu_result_o       = w_pop ? r_fifo_mem[r_rd_ptr] : 32'd0;
   assign bus.acc_req_valid_o    = r_req_valid;
   assign bus.acc_req_op_o       = r_req_op;
   assign bus.acc_req_operands_o = r_req_operands;
   assign bus.acc_rsp_ready_o    = ~w_full;
   assign bus.busy_o             = (r_credits != '0);

endmodule

// File: tb/tb_cv32e40p_apu_bridge.sv
// -----------------------------------------------------------------------------
// tb_cv32e40p_apu_bridge
//
// Directed scenarios followed by a randomized phase. Every cycle's outputs are
// compared with a transaction-level reference. In that reference, an
// operation is either waiting in the slot, in flight in the accelerator, or
// sitting in the result queue. The credit count is the number of operations
// granted but not yet returned to EX.
// -----------------------------------------------------------------------------
module tb_cv32e40p_apu_bridge;
   localparam int NARGS = 3;
   localparam int WOP   = 6;
   localparam int DEPTH = 2;

   typedef logic [NARGS-1:0][31:0] args_t;
   typedef struct packed {
      logic [WOP-1:0] op;
      args_t          a;
   } req_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cv32e40p_apu_bridge_if #(.APU_NARGS_CPU(NARGS), .APU_WOP_CPU(WOP)) bus ();

   cv32e40p_apu_bridge #(
      .APU_NARGS_CPU(NARGS),
      .APU_WOP_CPU  (WOP),
      .DEPTH        (DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Reference state
   int          credits;     // granted, not yet handed to EX
   req_t        slot_q[$];   // operation waiting for the accelerator
   logic [31:0] fifo_q[$];   // results buffered toward EX
   logic [31:0] accel_q[$];  // results the bench's accelerator still owes
   bit          acc_en;      // bench acts as the accelerator (random phase)
   int          checks;
   int          errors;
   int          cyc;

   function automatic logic [31:0] acc_fn(input req_t r);
      return ((r.a[0] ^ r.a[1]) + r.a[2]) + 32'(r.op);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic drive(input bit req, input logic [WOP-1:0] op, input args_t a,
                        input bit rdy, input bit rv, input logic [31:0] rd, input bit hold);
      bus.apu_req_i       = req;
      bus.apu_op_i        = op;
      bus.apu_operands_i  = a;
      bus.acc_req_ready_i = rdy;
      bus.acc_rsp_valid_i = rv;
      bus.acc_rsp_data_i  = rd;
      bus.rsp_hold_i      = hold;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, 1'b1, 1'b0, 32'd0, 1'b0);
   endtask

   task automatic model_reset();
      credits = 0;
      slot_q.delete();
      fifo_q.delete();
      accel_q.delete();
   endtask

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_gnt"},       32'(bus.apu_gnt_o), 32'd0);
      chk({pfx, "_rvalid"},    32'(bus.apu_rvalid_o), 32'd0);
      chk({pfx, "_result"},    bus.apu_result_o, 32'd0);
      chk({pfx, "_req_valid"}, 32'(bus.acc_req_valid_o), 32'd0);
      chk({pfx, "_req_op"},    32'(bus.acc_req_op_o), 32'd0);
      for (int i = 0; i < NARGS; i++) chk({pfx, "_operand"}, bus.acc_req_operands_o[i], 32'd0);
      chk({pfx, "_rsp_ready"}, 32'(bus.acc_rsp_ready_o), 32'd1);
      chk({pfx, "_busy"},      32'(bus.busy_o), 32'd0);
   endtask

   // Check all outputs against the reference, then advance one clock.
   task automatic tick();
      bit          e_gnt, e_pop, e_rdy, fire, rv;
      logic [31:0] rd;
      req_t        cur;
      #1;
      e_gnt = bus.apu_req_i && (credits < DEPTH) && (slot_q.size() == 0 || bus.acc_req_ready_i);
      e_pop = (fifo_q.size() != 0) && !bus.rsp_hold_i;
      e_rdy = fifo_q.size() < DEPTH;
      chk("gnt",       32'(bus.apu_gnt_o), 32'(e_gnt));
      chk("rvalid",    32'(bus.apu_rvalid_o), 32'(e_pop));
      chk("result",    bus.apu_result_o, e_pop ? fifo_q[0] : 32'd0);
      chk("rsp_ready", 32'(bus.acc_rsp_ready_o), 32'(e_rdy));
      chk("busy",      32'(bus.busy_o), 32'(credits != 0));
      chk("req_valid", 32'(bus.acc_req_valid_o), 32'(slot_q.size() != 0));
      if (slot_q.size() != 0) begin
         chk("req_op", 32'(bus.acc_req_op_o), 32'(slot_q[0].op));
         for (int i = 0; i < NARGS; i++) chk("req_operand", bus.acc_req_operands_o[i], slot_q[0].a[i]);
      end
      fire   = (slot_q.size() != 0) && bus.acc_req_ready_i;
      cur.op = bus.apu_op_i;
      cur.a  = bus.apu_operands_i;
      rv     = bus.acc_rsp_valid_i;
      rd     = bus.acc_rsp_data_i;
      @(posedge clk);
      if (fire) begin
         if (acc_en) accel_q.push_back(acc_fn(slot_q[0]));
         void'(slot_q.pop_front());
      end
      if (e_gnt) slot_q.push_back(cur);
      if (e_pop) void'(fifo_q.pop_front());
      if (rv && e_rdy) begin
         fifo_q.push_back(rd);
         if (acc_en) void'(accel_q.pop_front());
      end
      credits = credits + int'(e_gnt) - int'(e_pop);
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      args_t       a1, a2;
      bit          rv;
      logic [31:0] rd;
      args_t       ra;
      int          n;

      checks = 0;
      errors = 0;
      cyc    = 0;
      acc_en = 0;
      model_reset();
      rst = 1'b1;
      idle();

      // ---------------- reset state ----------------
      #1;
      chk_reset_outputs("rst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // ---------------- single op ----------------
      a1 = {32'd3, 32'd2, 32'd1};
      drive(1'b1, 6'h05, a1, 1'b1, 1'b0, 32'd0, 1'b0);
      #1 chk("single_gnt_c0", 32'(bus.apu_gnt_o), 32'd1);
      tick();
      idle();
      #1 chk("single_valid_c1", 32'(bus.acc_req_valid_o), 32'd1);
      chk("single_op_c1", 32'(bus.acc_req_op_o), 32'h05);
      chk("single_opnd0_c1", bus.acc_req_operands_o[0], 32'd1);
      chk("single_opnd2_c1", bus.acc_req_operands_o[2], 32'd3);
      tick();
      idle(); tick();
      drive(1'b0, '0, '0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0); tick();
      idle();
      #1 chk("single_rvalid_c4", 32'(bus.apu_rvalid_o), 32'd1);
      chk("single_result_c4", bus.apu_result_o, 32'hDEADBEEF);
      tick();
      idle();
      #1 chk("single_busy_c5", 32'(bus.busy_o), 32'd0);
      tick();

      // ---------------- credit limit ----------------
      a2 = {32'h30, 32'h20, 32'h10};
      drive(1'b1, 6'h01, a2, 1'b1, 1'b0, 32'd0, 1'b0);
      #1 chk("credit_gnt1", 32'(bus.apu_gnt_o), 32'd1);
      tick();
      drive(1'b1, 6'h02, a2, 1'b1, 1'b0, 32'd0, 1'b0);
      #1 chk("credit_gnt2", 32'(bus.apu_gnt_o), 32'd1);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 6'h03, a2, 1'b1, 1'b0, 32'd0, 1'b0);
         #1 chk("credit_gnt3_blocked", 32'(bus.apu_gnt_o), 32'd0);
         tick();
      end
      drive(1'b1, 6'h03, a2, 1'b1, 1'b1, 32'hA1, 1'b0);
      #1 chk("credit_blocked_push", 32'(bus.apu_gnt_o), 32'd0);
      tick();
      drive(1'b1, 6'h03, a2, 1'b1, 1'b0, 32'd0, 1'b0);
      #1 chk("credit_pop_result", bus.apu_result_o, 32'hA1);
      tick();
      drive(1'b1, 6'h03, a2, 1'b1, 1'b0, 32'd0, 1'b0);
      #1 chk("credit_gnt_after_pop", 32'(bus.apu_gnt_o), 32'd1);
      tick();
      drive(1'b0, '0, '0, 1'b1, 1'b1, 32'hA2, 1'b0); tick();
      drive(1'b0, '0, '0, 1'b1, 1'b1, 32'hA3, 1'b0); tick();
      idle(); tick();
      idle();
      #1 chk("credit_drained", 32'(bus.busy_o), 32'd0);
      tick();

      // ---------------- request stall ----------------
      a1 = {32'h11111111, 32'h22222222, 32'h33333333};
      a2 = {32'h44444444, 32'h55555555, 32'h66666666};
      drive(1'b1, 6'h2A, a1, 1'b0, 1'b0, 32'd0, 1'b0);
      #1 chk("stall_gnt0", 32'(bus.apu_gnt_o), 32'd1);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 6'h15, a2, 1'b0, 1'b0, 32'd0, 1'b0);
         #1 chk("stall_no_gnt", 32'(bus.apu_gnt_o), 32'd0);
         chk("stall_op_stable", 32'(bus.acc_req_op_o), 32'h2A);
         chk("stall_opnd_stable", bus.acc_req_operands_o[1], 32'h22222222);
         tick();
      end
      drive(1'b1, 6'h15, a2, 1'b1, 1'b0, 32'd0, 1'b0);
      #1 chk("stall_gnt_on_ready", 32'(bus.apu_gnt_o), 32'd1);
      tick();
      idle();
      #1 chk("stall_second_op", 32'(bus.acc_req_op_o), 32'h15);
      tick();
      drive(1'b0, '0, '0, 1'b1, 1'b1, 32'hB1, 1'b0); tick();
      drive(1'b0, '0, '0, 1'b1, 1'b1, 32'hB2, 1'b0); tick();
      idle(); tick();
      idle(); tick();

      // ---------------- hold ----------------
      drive(1'b1, 6'h07, a1, 1'b1, 1'b0, 32'd0, 1'b0); tick();
      drive(1'b1, 6'h08, a2, 1'b1, 1'b0, 32'd0, 1'b0); tick();
      idle(); tick();
      drive(1'b0, '0, '0, 1'b1, 1'b1, 32'h11, 1'b0); tick();
      drive(1'b0, '0, '0, 1'b1, 1'b1, 32'h22, 1'b1);
      #1 chk("hold_no_rvalid", 32'(bus.apu_rvalid_o), 32'd0);
      tick();
      drive(1'b0, '0, '0, 1'b1, 1'b0, 32'd0, 1'b1);
      #1 chk("hold_full_not_ready", 32'(bus.acc_rsp_ready_o), 32'd0);
      chk("hold_result_zero", bus.apu_result_o, 32'd0);
      tick();
      idle();
      #1 chk("hold_first", bus.apu_result_o, 32'h11);
      tick();
      idle();
      #1 chk("hold_second", bus.apu_result_o, 32'h22);
      tick();
      idle(); tick();

      // ---------------- reset mid-operation ----------------
      drive(1'b1, 6'h09, a1, 1'b1, 1'b0, 32'd0, 1'b0); tick();
      drive(1'b1, 6'h0A, a2, 1'b1, 1'b0, 32'd0, 1'b0); tick();
      idle(); tick();
      drive(1'b0, '0, '0, 1'b1, 1'b1, 32'h33, 1'b1); tick();
      drive(1'b0, '0, '0, 1'b1, 1'b0, 32'd0, 1'b1);
      #1 chk("midrst_busy_before", 32'(bus.busy_o), 32'd1);
      rst = 1'b1;
      #1 chk_reset_outputs("midrst");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // ---------------- simultaneous events, pointers wrap ----------------
      drive(1'b1, 6'h0B, a1, 1'b1, 1'b0, 32'd0, 1'b0); tick();
      drive(1'b1, 6'h0C, a2, 1'b1, 1'b0, 32'd0, 1'b0); tick();
      drive(1'b0, '0, '0, 1'b1, 1'b1, 32'hC1, 1'b0); tick();
      drive(1'b0, '0, '0, 1'b1, 1'b1, 32'hC2, 1'b0);
      #1 chk("sim_pushpop_result", bus.apu_result_o, 32'hC1);
      tick();
      drive(1'b1, 6'h0D, a1, 1'b1, 1'b0, 32'd0, 1'b0);
      #1 chk("sim_gntpop_gnt", 32'(bus.apu_gnt_o), 32'd1);
      chk("sim_gntpop_result", bus.apu_result_o, 32'hC2);
      tick();
      idle();
      #1 chk("sim_credit_kept", 32'(bus.busy_o), 32'd1);
      chk("sim_fifo_empty", 32'(bus.apu_rvalid_o), 32'd0);
      tick();
      drive(1'b0, '0, '0, 1'b1, 1'b1, 32'hC3, 1'b0); tick();
      idle();
      #1 chk("sim_wrapped_data", bus.apu_result_o, 32'hC3);
      tick();
      idle(); tick();

      // ---------------- randomized traffic ----------------
      acc_en = 1;
      for (int k = 0; k < 600; k++) begin
         for (int i = 0; i < NARGS; i++) ra[i] = $urandom;
         rv = (accel_q.size() != 0) && ($urandom_range(2) != 0);
         rd = rv ? accel_q[0] : $urandom;
         drive($urandom_range(3) != 0, WOP'($urandom), ra, $urandom_range(3) != 0,
               rv, rd, $urandom_range(3) == 0);
         tick();
      end
      n = 0;
      while ((credits != 0) && (n < 200)) begin
         rv = (accel_q.size() != 0);
         drive(1'b0, '0, '0, 1'b1, rv, rv ? accel_q[0] : 32'd0, 1'b0);
         tick();
         n++;
      end
      idle();
      #1 chk("drain_busy", 32'(bus.busy_o), 32'd0);
      chk("drain_model_credits", 32'(credits), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
